spu_writeback_stage: RTL
========================

// Module: spu_writeback_stage
// PURPOSE
//   Write-back staging unit: the producer side of the register file's two write ports.
//   Each pipe (even -> write port 1, odd -> write port 2) accepts finished results with a
//   per-result hold delay; a shift pipeline aligns them to one retire point and drives
//   reg_write_en/addr/data. Sits between the execution units and the register file.
//   Also resolves same-address dual writes and flushes staged results.
// PARAMETERS
//   DEPTH   8    staging slots per pipe (slot 0 = retire slot)
//   ADDR_W  7    register address width (128 registers)
//   DATA_W  128  register data width
//   DLY_W   3    width of res_delay_x; equals $clog2(DEPTH)
// PORTS
//   clk               in   1       clock; all state updates on posedge
//   rst               in   1       asynchronous reset, active-low (asserted when 0)
//   res_valid_1       in   1       even-pipe result present this cycle
//   res_addr_1        in   ADDR_W  even-pipe destination register
//   res_data_1        in   DATA_W  even-pipe result data
//   res_delay_1       in   DLY_W   even-pipe hold cycles d
//   res_valid_2       in   1       odd-pipe result present this cycle
//   res_addr_2        in   ADDR_W  odd-pipe destination register
//   res_data_2        in   DATA_W  odd-pipe result data
//   res_delay_2       in   DLY_W   odd-pipe hold cycles d
//   flush             in   1       discard all staged, not-yet-retiring results
//   err_clr           in   1       clears err_sticky
//   reg_write_en_1    out  1       write enable, register-file port 1
//   reg_write_addr_1  out  ADDR_W  write address, port 1
//   reg_write_data_1  out  DATA_W  write data, port 1
//   reg_write_en_2    out  1       write enable, register-file port 2
//   reg_write_addr_2  out  ADDR_W  write address, port 2
//   reg_write_data_2  out  DATA_W  write data, port 2
//   busy              out  1       any slot in either pipe valid (registered-state OR)
//   err_pulse         out  1       one-cycle pulse: a result was dropped (registered)
//   err_sticky        out  1       set by err_pulse; cleared by err_clr or reset
// BEHAVIOUR
//   - Reset (rst=0, async): all slot valid bits, err_pulse and err_sticky = 0.
//     Consequently all write enables = 0 and busy = 0. Addr/data outputs reset to 0.
//   - Per pipe p, per cycle without flush:
//     - slot[i] <= slot[i+1] for i < DEPTH-1, and slot[DEPTH-1] <= empty.
//     - Then, if res_valid_p, the insert writes slot[d], overriding the shifted value.
//   - Latency: result presented in cycle t with delay d appears on write port p in cycle t+1+d.
//     - d=0 gives 1 cycle.
//     - Maximum latency is DEPTH cycles.
//   - Write port p outputs come from slot[0]: addr/data direct, en = slot[0].valid.
//   - Slot conflict: the insert targets d, but slot[d+1] is valid (d = DEPTH-1 never conflicts).
//     - The existing entry is kept and the new result is dropped.
//     - err_pulse is asserted next cycle and err_sticky is set.
//   - Illegal delay: res_delay_p >= DEPTH (only when DEPTH is not a power of 2).
//     - The result is dropped and an error is raised, same as a conflict.
//   - Both pipes erroring in one cycle: single err_pulse.
//   - Dual-write hazard: both slot[0] valid with equal addr.
//     - reg_write_en_1 is forced to 0; port 2 (odd pipe, younger) wins.
//     - No error is raised. This is combinational on the slot-0 registers.
//   - Flush in cycle t: the slot-0 writes presented in cycle t still commit (outputs unaffected in t).
//     - Every slot of both pipes is empty at t+1.
//     - Any res_valid in cycle t is discarded without error.
//   - err_clr and err_pulse in the same cycle: the set wins, so err_sticky remains 1.
//   - Reset mid-operation: staged results are lost and no write enable is asserted while rst=0.
// TESTING
//   1. Reset, then pipe1 res addr=5 data=A d=0 at t -> en_1=1 addr=5 data=A at t+1 only; busy=0 at t+2.
//   2. Pipe1 d=7 addr=3 at t, d=0 addr=4 at t+6 -> addr 4 retires t+7, addr 3 t+8, no error.
//   3. Pipe2 d=3 at t, then d=2 at t+1 (same slot) -> second dropped, err_pulse t+2, err_sticky=1, only first writes.
//   4. Both pipes d=1 addr=9 data1=X data2=Y -> at t+2 en_1=0, en_2=1 addr=9 data=Y.
//   5. Stage 3 results, assert flush while one sits in slot0 -> that one writes, no later enables, busy=0 next cycle.
//   6. Pull rst low with 4 staged results -> all enables 0 immediately, busy=0, err_sticky=0 after release.

Source files
------------

// File: rtl/spu_writeback_stage.sv
// Write-back staging for the two register-file write ports.
// Delayed results shift toward slot 0 and retire from there.
module spu_writeback_stage #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128,
    parameter int DLY_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid_1,
    input  logic [ADDR_W-1:0] res_addr_1,
    input  logic [DATA_W-1:0] res_data_1,
    input  logic [DLY_W-1:0]  res_delay_1,
    input  logic              res_valid_2,
    input  logic [ADDR_W-1:0] res_addr_2,
    input  logic [DATA_W-1:0] res_data_2,
    input  logic [DLY_W-1:0]  res_delay_2,
    input  logic              flush,
    input  logic              err_clr,
    output logic              reg_write_en_1,
    output logic [ADDR_W-1:0] reg_write_addr_1,
    output logic [DATA_W-1:0] reg_write_data_1,
    output logic              reg_write_en_2,
    output logic [ADDR_W-1:0] reg_write_addr_2,
    output logic [DATA_W-1:0] reg_write_data_2,
    output logic              busy,
    output logic              err_pulse,
    output logic              err_sticky
);

    localparam int NP = 2;

    logic [DEPTH-1:0]  vld_q  [NP];
    logic [DEPTH-1:0]  vld_d  [NP];
    logic [ADDR_W-1:0] addr_q [NP][DEPTH];
    logic [ADDR_W-1:0] addr_d [NP][DEPTH];
    logic [DATA_W-1:0] data_q [NP][DEPTH];
    logic [DATA_W-1:0] data_d [NP][DEPTH];
    logic              err_pulse_q, err_pulse_d;
    logic              err_sticky_q, err_sticky_d;

    logic              in_v  [NP];
    logic [ADDR_W-1:0] in_a  [NP];
    logic [DATA_W-1:0] in_dt [NP];
    logic [DLY_W-1:0]  in_dl [NP];
    logic [NP-1:0]     drop;
    logic              hazard;

    // Gather both pipes' inputs so the slot logic can loop over them.
    always_comb begin
        in_v[0]  = res_valid_1;
        in_a[0]  = res_addr_1;
        in_dt[0] = res_data_1;
        in_dl[0] = res_delay_1;
        in_v[1]  = res_valid_2;
        in_a[1]  = res_addr_2;
        in_dt[1] = res_data_2;
        in_dl[1] = res_delay_2;
    end

    // Shift every pipe one slot, then insert the new result at its delay slot.
    always_comb begin
        err_pulse_d = 1'b0;
        drop        = '0;
        for (int p = 0; p < NP; p++) begin
            vld_d[p] = {1'b0, vld_q[p][DEPTH-1:1]};
            for (int i = 0; i < DEPTH-1; i++) begin
                addr_d[p][i] = addr_q[p][i+1];
                data_d[p][i] = data_q[p][i+1];
            end
            addr_d[p][DEPTH-1] = addr_q[p][DEPTH-1];
            data_d[p][DEPTH-1] = data_q[p][DEPTH-1];
            if (in_v[p]) begin
                if (int'(in_dl[p]) >= DEPTH) begin
                    drop[p] = 1'b1;
                end
                // The slot above the target is what shifts into it.
                for (int i = 0; i < DEPTH-1; i++) begin
                    if (int'(in_dl[p]) == i && vld_q[p][i+1]) begin
                        drop[p] = 1'b1;
                    end
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (int'(in_dl[p]) == i && !drop[p]) begin
                        vld_d[p][i]  = 1'b1;
                        addr_d[p][i] = in_a[p];
                        data_d[p][i] = in_dt[p];
                    end
                end
            end
            if (flush) begin
                vld_d[p] = '0;
                drop[p]  = 1'b0;
            end
        end
        err_pulse_d  = |drop;
        // A pending or just-issued pulse beats a simultaneous clear.
        err_sticky_d = err_pulse_d | err_pulse_q |
                       (err_sticky_q & ~err_clr);
    end

    // Slot and error state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                vld_q[p] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    addr_q[p][i] <= '0;
                    data_q[p][i] <= '0;
                end
            end
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                vld_q[p] <= vld_d[p];
                for (int i = 0; i < DEPTH; i++) begin
                    addr_q[p][i] <= addr_d[p][i];
                    data_q[p][i] <= data_d[p][i];
                end
            end
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Same-address dual write: the odd pipe is younger and wins.
    assign hazard = vld_q[0][0] & vld_q[1][0] &
                    (addr_q[0][0] == addr_q[1][0]);

    assign reg_write_en_1   = vld_q[0][0] & ~hazard;
    assign reg_write_addr_1 = addr_q[0][0];
    assign reg_write_data_1 = data_q[0][0];
    assign reg_write_en_2   = vld_q[1][0];
    assign reg_write_addr_2 = addr_q[1][0];
    assign reg_write_data_2 = data_q[1][0];
    assign busy             = (|vld_q[0]) | (|vld_q[1]);
    assign err_pulse        = err_pulse_q;
    assign err_sticky       = err_sticky_q;

endmodule
